dmem_arbiter: RTL

//   Shares the single-port data memory between two requesters: the pipeline

---
 rtl/dmem_arb_pkg.sv | 40 ++++
 rtl/dmem_arbiter_check.sv | 17 +
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types, funct3 codes and access-legality helper
// for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {ARB, DBG_HOLD} arb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic access_err(
    input logic        we,
    input logic [2:0]  funct3,
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    logic bad_f3;
    logic half;
    logic word;
    logic mis;
    logic oor;
    if (we)
      bad_f3 = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    else
      bad_f3 = !(funct3 inside
        {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    half = funct3 inside {F3_LH, F3_LHU};
    word = (funct3 == F3_LW);
    mis  = (half && addr[0]) ||
           (word && (addr[1:0] != 2'b00));
    oor  = {2'b00, addr[31:2]} >= depth;
    return bad_f3 | mis | oor;
  endfunction

endpackage

// File: rtl/dmem_arbiter_check.sv
// Combinational legality decode of the winning request
// (funct3, alignment, range).
import dmem_arb_pkg::*;

module dmem_access_check #(
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  assign err_o = access_err(we_i, funct3_i, addr_i,
                            32'(DEPTH_WORDS));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory:
// core vs. debug, with starvation guard and debug lock.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned LOCK_MAX    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_funct3_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [2:0]  dbg_funct3_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic        dbg_lock_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dataW_o,
  output logic [2:0]  mem_funct3_o,
  output logic        mem_MemRW_o,
  input  logic [31:0] mem_dataR_i
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);

  arb_state_t     state_q, state_d;
  logic [SCW-1:0] starve_q, starve_d;
  logic [LCW-1:0] lock_q, lock_d;
  logic           lblk_q, lblk_d;

  logic           c_rv_q, c_err_q;
  logic [31:0]    c_rdata_q;
  logic           d_rv_q, d_err_q;
  logic [31:0]    d_rdata_q;

  logic           core_gnt, dbg_gnt, any_gnt;
  logic           w_we, w_err;
  logic [2:0]     w_f3;
  logic [31:0]    w_addr, w_wdata;
  logic           rd_ok;

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ARB: begin
          if (dbg_req_i && (!core_req_i ||
              starve_q == SCW'(STARVE_MAX)))
            dbg_gnt = 1'b1;
          else
            core_gnt = core_req_i;
        end
        DBG_HOLD: dbg_gnt = dbg_req_i;
        default: ;
      endcase
    end
  end

  assign any_gnt = core_gnt | dbg_gnt;
  assign w_we    = dbg_gnt ? dbg_we_i     : core_we_i;
  assign w_f3    = dbg_gnt ? dbg_funct3_i : core_funct3_i;
  assign w_addr  = dbg_gnt ? dbg_addr_i   : core_addr_i;
  assign w_wdata = dbg_gnt ? dbg_wdata_i  : core_wdata_i;

  dmem_access_check #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_check (
    .we_i    (w_we),
    .funct3_i(w_f3),
    .addr_i  (w_addr),
    .err_o   (w_err)
  );

  assign mem_addr_o   = any_gnt ? w_addr  : '0;
  assign mem_dataW_o  = any_gnt ? w_wdata : '0;
  assign mem_funct3_o = any_gnt ? w_f3    : '0;
  assign mem_MemRW_o  = any_gnt & w_we & ~w_err;
  assign rd_ok        = ~w_we & ~w_err;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;
    lblk_d   = lblk_q;
    if (!dbg_req_i || dbg_gnt)
      starve_d = '0;
    else if (starve_q != SCW'(STARVE_MAX))
      starve_d = starve_q + 1'b1;
    if (!dbg_lock_i)
      lblk_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (dbg_gnt && dbg_lock_i && !lblk_q) begin
          state_d = DBG_HOLD;
          lock_d  = '0;
        end
      end
      DBG_HOLD: begin
        lock_d = lock_q + 1'b1;
        if (!dbg_lock_i) begin
          state_d = ARB;
        end else if (lock_q == LCW'(LOCK_MAX - 1)) begin
          // forced release: no re-lock until dbg_lock drops
          state_d = ARB;
          lblk_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB;
      starve_q  <= '0;
      lock_q    <= '0;
      lblk_q    <= 1'b0;
      c_rv_q    <= 1'b0;
      c_err_q   <= 1'b0;
      c_rdata_q <= '0;
      d_rv_q    <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      lock_q    <= lock_d;
      lblk_q    <= lblk_d;
      c_rv_q    <= core_gnt;
      c_err_q   <= core_gnt & w_err;
      c_rdata_q <= (core_gnt & rd_ok) ? mem_dataR_i : '0;
      d_rv_q    <= dbg_gnt;
      d_err_q   <= dbg_gnt & w_err;
      d_rdata_q <= (dbg_gnt & rd_ok) ? mem_dataR_i : '0;
    end
  end

  // a response in flight when reset arrives is dropped
  assign core_gnt_o    = core_gnt;
  assign dbg_gnt_o     = dbg_gnt;
  assign core_rvalid_o = c_rv_q & ~rst_i;
  assign core_err_o    = c_err_q & ~rst_i;
  assign core_rdata_o  = rst_i ? '0 : c_rdata_q;
  assign dbg_rvalid_o  = d_rv_q & ~rst_i;
  assign dbg_err_o     = d_err_q & ~rst_i;
  assign dbg_rdata_o   = rst_i ? '0 : d_rdata_q;

endmodule
